// File: rtl/sipo_pkg.sv
// Shared definitions for the serial receive path: state encoding, line levels
// and the parity helper used by the frame controller.
package sipo_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE   = IDLE,
        S_DATA   = DATA,
        S_PARITY = PARITY,
        S_STOP   = STOP
    } state_t;

    // Expected parity bit for a zero-extended data word; odd=1 flips the sense.
    function automatic logic parity_bit(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sipo_shift_en.sv
// Enable-gated serial-in/parallel-out shift register; new bits enter at the LSB
// so the first bit received ends up at the MSB.
module sipo_shift_en #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge Clk) begin
        if (!rst) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], in};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Receive-side frame controller: start detect, WIDTH data bits, optional parity,
// stop check, and a valid/ready holding register for good words.
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             in,
    input  logic             enable,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              perr;
    logic              shift_en;
    logic [WIDTH-1:0]  shreg;
    logic [31:0]       pdata;

    assign shift_en = (state == S_DATA) && enable;
    assign pdata    = 32'(shreg);

    sipo_shift_en #(
        .WIDTH (WIDTH)
    ) u_shift (
        .Clk      (Clk),
        .rst      (rst),
        .shift_en (shift_en),
        .in       (in),
        .q        (shreg)
    );

    always_ff @(posedge Clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            perr      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Losing enable mid-frame drops the partial frame silently.
            if (state != S_IDLE && !enable) begin
                state <= S_IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (enable && in == START_LEVEL) begin
                            state <= S_DATA;
                            cnt   <= '0;
                            perr  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        // Clear rather than increment on the last bit so the
                        // counter never wraps when WIDTH is a power of two.
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= PARITY_EN ? S_PARITY : S_STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        perr  <= (in != parity_bit(pdata, ODD_PARITY));
                        state <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (in == IDLE_LEVEL && !perr) begin
                            out_data  <= shreg;
                            out_valid <= 1'b1;
                            overrun   <= out_valid && !out_ready;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: frame table with scoreboard plus
// hand sequences for reset, abort and the no-parity variant.
module tb_sipo_frame_ctrl;

    logic       Clk = 1'b0;
    logic       rst = 1'b0, in = 1'b1, enable = 1'b0, out_ready = 1'b0;
    logic [3:0] out_data;
    logic       out_valid, frame_err, overrun, busy;

    logic       rst0 = 1'b0, in0 = 1'b1, en0 = 1'b0, rdy0 = 1'b0;
    logic [3:0] out_data0;
    logic       out_valid0, frame_err0, overrun0, busy0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] d;
        logic       p;
        logic       s;
        logic       rdy;
        logic       drain;
        logic       exp_v;
        logic [3:0] exp_d;
        logic       exp_e;
        logic       exp_o;
    } vec_t;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       e;
        logic       o;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1'b1), .ODD_PARITY(1'b0)) dut (
        .Clk(Clk), .rst(rst), .in(in), .enable(enable),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1'b0), .ODD_PARITY(1'b0)) dut0 (
        .Clk(Clk), .rst(rst0), .in(in0), .enable(en0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(rdy0),
        .frame_err(frame_err0), .overrun(overrun0), .busy(busy0)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] d, input logic p, input logic s, input logic rdy);
        in = 1'b0;
        step();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_err_clear", 32'(frame_err), 32'd0);
        chk("start_ovr_clear", 32'(overrun), 32'd0);
        for (int i = 3; i >= 0; i--) begin
            in = d[i];
            step();
        end
        in = p;
        step();
        chk("parity_busy", 32'(busy), 32'd1);
        in = s;
        out_ready = rdy;
        step();
        in = 1'b1;
        out_ready = 1'b0;
    endtask

    initial begin
        exp_t e;

        vecs[0] = '{4'b1011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[1] = '{4'b1011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0};
        vecs[2] = '{4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b0};
        vecs[3] = '{4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0};
        vecs[4] = '{4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b1};
        vecs[5] = '{4'b1011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0};
        vecs[6] = '{4'b1110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1110, 1'b0, 1'b0};
        vecs[7] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0};

        // Reset held two cycles with the line toggling and the receiver armed.
        enable = 1'b1;
        rst = 1'b0; rst0 = 1'b0;
        in = 1'b0; in0 = 1'b0;
        step();
        in = 1'b1; in0 = 1'b1;
        step();
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst0_valid", 32'(out_valid0), 32'd0);
        chk("rst0_busy", 32'(busy0), 32'd0);
        rst = 1'b1; rst0 = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            e.v = vecs[i].exp_v;
            e.d = vecs[i].exp_d;
            e.e = vecs[i].exp_e;
            e.o = vecs[i].exp_o;
            sb.push_back(e);
            send(vecs[i].d, vecs[i].p, vecs[i].s, vecs[i].rdy);
            e = sb.pop_front();
            chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(e.v));
            chk($sformatf("row%0d_data", i), 32'(out_data), 32'(e.d));
            chk($sformatf("row%0d_err", i), 32'(frame_err), 32'(e.e));
            chk($sformatf("row%0d_ovr", i), 32'(overrun), 32'(e.o));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'd0);
            if (vecs[i].drain) begin
                step();
                step();
                chk($sformatf("row%0d_hold_valid", i), 32'(out_valid), 32'd1);
                chk($sformatf("row%0d_hold_data", i), 32'(out_data), 32'(e.d));
                chk($sformatf("row%0d_err_pulse", i), 32'(frame_err), 32'd0);
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
                chk($sformatf("row%0d_consumed", i), 32'(out_valid), 32'd0);
            end
        end

        // Park a good word, then abort a frame on its third data bit.
        send(4'b1101, 1'b1, 1'b1, 1'b0);
        chk("park_valid", 32'(out_valid), 32'd1);
        chk("park_data", 32'(out_data), 32'hd);
        in = 1'b0; step();
        in = 1'b1; step();
        in = 1'b0; step();
        enable = 1'b0; in = 1'b1;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_err", 32'(frame_err), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd1);
        chk("abort_data", 32'(out_data), 32'hd);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_abort_err", 32'(frame_err), 32'd0);
            chk("post_abort_busy", 32'(busy), 32'd0);
        end

        // Reset in the middle of a frame.
        in = 1'b0; step();
        in = 1'b1; step();
        in = 1'b1; step();
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midrst_data", 32'(out_data), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_err", 32'(frame_err), 32'd0);
        chk("midrst_ovr", 32'(overrun), 32'd0);
        step();
        chk("midrst_idle", 32'(busy), 32'd0);

        // No-parity instance: commit one edge earlier, then a bad stop.
        en0 = 1'b1;
        in0 = 1'b0; step();
        chk("np_busy", 32'(busy0), 32'd1);
        in0 = 1'b1; step();
        in0 = 1'b0; step();
        in0 = 1'b1; step();
        in0 = 1'b1; step();
        chk("np_valid_early", 32'(out_valid0), 32'd0);
        chk("np_busy_stop", 32'(busy0), 32'd1);
        in0 = 1'b1; step();
        chk("np_valid", 32'(out_valid0), 32'd1);
        chk("np_data", 32'(out_data0), 32'hb);
        chk("np_err", 32'(frame_err0), 32'd0);
        chk("np_idle", 32'(busy0), 32'd0);
        in0 = 1'b0; step();
        in0 = 1'b0; step();
        in0 = 1'b1; step();
        in0 = 1'b1; step();
        in0 = 1'b0; step();
        in0 = 1'b0; step();
        chk("np_badstop_err", 32'(frame_err0), 32'd1);
        chk("np_badstop_data", 32'(out_data0), 32'hb);
        chk("np_badstop_ovr", 32'(overrun0), 32'd0);
        in0 = 1'b1; step();
        chk("np_err_pulse", 32'(frame_err0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
Receive-side controller for the serial-in/parallel-out shifter. It detects a start bit on the serial line and sequences the shift register for exactly WIDTH data bits. It then checks an optional parity bit and the stop bit, and commits good words to a holding register with a valid/ready handshake. It sits between the serial pin and any parallel consumer.

Parameters:
WIDTH, 4, data bits per frame; legal range 2..32.
PARITY_EN, 1, 1 = one parity bit follows the data; 0 = no parity bit.
ODD_PARITY, 0, 0 = even parity (data plus parity bit has an even count of ones); 1 = odd parity.

Ports:
Clk  input  1  clock; all state changes on the rising edge.
rst  input  1  reset, synchronous, active-low.
in  input  1  serial line; idle level 1, start bit 0, one bit per Clk.
enable  input  1  1 = receiver armed.
out_data  output  WIDTH  last good word; first received bit is at out_data[WIDTH-1] (MSB-first).
out_valid  output  1  out_data holds an unconsumed word.
out_ready  input  1  consumer accepts the word on a cycle where out_valid=1 and out_ready=1.
frame_err  output  1  one-cycle pulse when a frame has bad parity or a bad stop bit.
overrun  output  1  one-cycle pulse when an unconsumed word is overwritten.
busy  output  1  1 in every state except IDLE.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, bit counter=0, shift register=0, out_data=0. out_valid, frame_err, overrun and busy are all 0. Reset has priority over all other inputs, including mid-frame; a partial frame is discarded.
- States: IDLE, DATA, PARITY, STOP.
- IDLE: if enable=1 and in=0, the start bit is consumed and the next state is DATA with counter=0. Otherwise stay in IDLE.
- DATA: each cycle, shift `in` into the shift register (shift toward the MSB) and increment the counter.
  - When counter reaches WIDTH-1, go to PARITY if PARITY_EN=1, else to STOP.
  - Counter width is $clog2(WIDTH); it never wraps inside a frame.
- PARITY: sample `in` as the parity bit, register a parity-error flag, go to STOP.
- STOP: sample `in`, then return to IDLE. In that IDLE cycle a new start bit is already accepted, so back-to-back frames need no gap.
  - Good frame (stop=1 and no parity error): on the next edge, out_data is loaded from the shift register and out_valid=1.
  - Bad frame: frame_err pulses high for one cycle, out_data is unchanged, out_valid is unchanged.
- Latency: with the start bit sampled at edge 0, out_valid rises at edge WIDTH+2 when PARITY_EN=1, or WIDTH+1 when PARITY_EN=0 (registered, visible the cycle after the stop sample).
- Handshake:
  - out_valid stays 1 and out_data stays stable until out_ready=1 is sampled. out_valid then falls on that edge unless a new good word commits on the same edge.
  - Commit and out_ready on the same edge: the old word is consumed, the new word loads, out_valid stays 1, no overrun.
  - Commit while out_valid=1 and out_ready=0: the new word overwrites and overrun pulses for one cycle.
- enable=0 in any non-IDLE state: abort to IDLE on the next edge; no commit, no frame_err. The holding register and out_valid are unaffected.
- out_data, out_valid, frame_err, overrun and busy are all registered outputs.

Decomposition:
- Package sipo_pkg holds:
  - state encoding localparams: IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3;
  - IDLE_LEVEL=1'b1 and START_LEVEL=1'b0;
  - a parity function (reduction XOR with the ODD_PARITY adjust).
- One natural sub-module: sipo_shift_en, a WIDTH-bit enable-gated shift register (Clk, rst, shift_en, in, q). The controller drives shift_en only in DATA.

Test Plan (WIDTH=4, PARITY_EN=1, ODD_PARITY=0 unless noted):
1. Reset: hold rst=0 for 2 cycles with in toggling -> out_data=0, out_valid=0, busy=0, frame_err=0, overrun=0.
2. Good frame, enable=1, out_ready=0: in = 0 (start), data 1,0,1,1, parity 1, stop 1 -> out_data=4'b1011 and out_valid=1 at edge 6 after the start edge. Both hold until out_ready=1, then out_valid=0 next cycle.
3. Bad parity: same frame but parity bit 0 -> frame_err is high for exactly one cycle, out_valid stays 0, out_data stays 0.
4. Bad stop: data 0,1,1,0, parity 0, stop 0 -> frame_err pulse, no commit. A start bit on the very next cycle begins a new frame (busy=1).
5. Overrun: two back-to-back good frames (4'b1011, then 4'b0110) with out_ready=0 -> overrun pulses once, out_data=4'b0110, out_valid=1. Repeat with out_ready=1 on the second commit edge -> no overrun pulse.
6. Abort: drop enable during the third data bit -> busy=0 next cycle, no out_valid, no frame_err. Separately, assert rst=0 mid-frame -> all outputs return to reset values. Also rerun scenario 2 with PARITY_EN=0 -> out_valid at edge 5.
